// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared constants and types for the memory-stage load/store unit.
//   F3_*   : funct3 encodings of the supported load/store sizes
//   EXC_*  : exception codes reported on exc_code_M
//   lsu_state_e : FSM states of mem_access_unit
//   isMisaligned() : alignment rule for a given size and byte offset
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] EXC_NONE       = 2'b00;
  localparam logic [1:0] EXC_MISALIGNED = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT    = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } lsu_state_e;

  // Halfwords need an even address, words a 4-byte aligned one;
  // bytes can sit anywhere.
  function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_H, F3_HU: return offset[0];
      F3_W:        return offset != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align
// Purely combinational lane steering for the load/store unit.
//   offset_i : byte offset within the word (addr[1:0])
//   funct3_i : access size/sign
//   data_i   : store source data (store use) or bus read word (load use)
//   be_o     : byte enables for the access
//   wdata_o  : lane-replicated store data
//   ldata_o  : selected and sign/zero-extended load result
// The top instantiates one copy per direction and only consumes the
// outputs that matter for that direction.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);

  logic [31:0] shifted;

  // Bring the addressed byte/half down to bit 0 so extraction is uniform.
  assign shifted = data_i >> {offset_i, 3'b000};

  // Store path: replicate the source across every lane so the memory only
  // has to honour the byte enables.
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{data_i[7:0]}};
      end
      2'b01: begin
        be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = data_i;
      end
    endcase
  end

  // Load path: extend the selected lane according to the signedness bit.
  always_comb begin
    ldata_o = data_i;
    case (funct3_i)
      F3_B:    ldata_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ldata_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   ldata_o = {24'h000000, shifted[7:0]};
      F3_HU:   ldata_o = {16'h0000, shifted[15:0]};
      default: ldata_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store unit: turns the M-stage memory op into a single
// req/ack data-memory transaction and returns the extended load result.
//   clk, rst           : clock, synchronous active-high reset
//   alu_result_M       : effective byte address
//   rs2_rdata_M        : store source data
//   funct3_M           : access size/sign
//   MemRead_M/Write_M  : load / store present in M
//   flush_M            : M instruction is squashed
//   dmem_*             : data-memory bus (req held until ack)
//   stall_M            : freeze upstream pipeline while the access is in flight
//   load_valid_M/data  : one-cycle load result
//   exc_M/exc_code_M   : one-cycle exception pulse and its cause
module mem_access_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result_M,
  input  logic [31:0] rs2_rdata_M,
  input  logic [2:0]  funct3_M,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic        flush_M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_M,
  output logic        load_valid_M,
  output logic [31:0] load_data_M,
  output logic        exc_M,
  output logic [1:0]  exc_code_M
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e  state_q;
  logic        dmemReq_q;
  logic        dmemWe_q;
  logic [31:0] dmemAddr_q;
  logic [31:0] dmemWdata_q;
  logic [3:0]  dmemBe_q;
  logic [1:0]  loadOff_q;
  logic [2:0]  loadF3_q;
  logic        loadValid_q;
  logic [31:0] loadData_q;
  logic        exc_q;
  logic [1:0]  excCode_q;
  logic [CNT_W-1:0] timeoutCnt_q;

  logic        accessValid;
  logic        illegalAccess;
  logic        misalignedAccess;
  logic [3:0]  stBe;
  logic [31:0] stWdata;
  logic [31:0] ldResult;
  logic [31:0] unusedStLdata;
  logic [3:0]  unusedLdBe;
  logic [31:0] unusedLdWdata;

  // Decode of the op currently sitting in M; only acted on in IDLE.
  assign accessValid      = (MemRead_M || MemWrite_M) && !flush_M;
  assign illegalAccess    = (MemRead_M && MemWrite_M)
                         || (funct3_M inside {3'b011, 3'b110, 3'b111})
                         || (MemWrite_M && funct3_M[2]);
  assign misalignedAccess = isMisaligned(funct3_M, alu_result_M[1:0]);

  // Request-side steering from the live M-stage operands.
  lsu_align u_store_align (
    .offset_i (alu_result_M[1:0]),
    .funct3_i (funct3_M),
    .data_i   (rs2_rdata_M),
    .be_o     (stBe),
    .wdata_o  (stWdata),
    .ldata_o  (unusedStLdata)
  );

  // Response-side extraction uses the offset/size captured at request time,
  // because the M-stage inputs are not guaranteed to hold through the ack.
  lsu_align u_load_align (
    .offset_i (loadOff_q),
    .funct3_i (loadF3_q),
    .data_i   (dmem_rdata),
    .be_o     (unusedLdBe),
    .wdata_o  (unusedLdWdata),
    .ldata_o  (ldResult)
  );

  // Stall only for accesses that will actually go on the bus; exceptions
  // let the instruction drain so downstream flush logic can discard it.
  assign stall_M = ((state_q == IDLE) && accessValid && !illegalAccess && !misalignedAccess)
                || (state_q == BUSY);

  // Main FSM. Pulse outputs default low every cycle; bus fields are only
  // loaded when a request starts so they stay stable while dmem_req is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      dmemReq_q    <= 1'b0;
      dmemWe_q     <= 1'b0;
      dmemAddr_q   <= '0;
      dmemWdata_q  <= '0;
      dmemBe_q     <= '0;
      loadOff_q    <= '0;
      loadF3_q     <= '0;
      loadValid_q  <= 1'b0;
      loadData_q   <= '0;
      exc_q        <= 1'b0;
      excCode_q    <= EXC_NONE;
      timeoutCnt_q <= '0;
    end else begin
      loadValid_q <= 1'b0;
      exc_q       <= 1'b0;
      excCode_q   <= EXC_NONE;
      case (state_q)
        IDLE: begin
          if (accessValid) begin
            if (illegalAccess) begin
              exc_q     <= 1'b1;
              excCode_q <= EXC_ILLEGAL;
            end else if (misalignedAccess) begin
              exc_q     <= 1'b1;
              excCode_q <= EXC_MISALIGNED;
            end else begin
              dmemReq_q    <= 1'b1;
              dmemWe_q     <= MemWrite_M;
              dmemAddr_q   <= {alu_result_M[31:2], 2'b00};
              dmemBe_q     <= stBe;
              dmemWdata_q  <= stWdata;
              loadOff_q    <= alu_result_M[1:0];
              loadF3_q     <= funct3_M;
              timeoutCnt_q <= '0;
              state_q      <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dmem_ack) begin
            dmemReq_q   <= 1'b0;
            loadValid_q <= !dmemWe_q;
            if (!dmemWe_q) begin
              loadData_q <= ldResult;
            end
            state_q <= RESP;
          end else if (timeoutCnt_q == CNT_W'(TIMEOUT - 1)) begin
            dmemReq_q    <= 1'b0;
            exc_q        <= 1'b1;
            excCode_q    <= EXC_TIMEOUT;
            timeoutCnt_q <= '0;
            state_q      <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign dmem_req     = dmemReq_q;
  assign dmem_we      = dmemWe_q;
  assign dmem_addr    = dmemAddr_q;
  assign dmem_wdata   = dmemWdata_q;
  assign dmem_be      = dmemBe_q;
  assign load_valid_M = loadValid_q;
  assign load_data_M  = loadData_q;
  assign exc_M        = exc_q;
  assign exc_code_M   = excCode_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Table of M-stage memory ops with hand-computed results; a bus responder
// inside applyStimulus answers requests after a per-vector number of wait
// cycles. Expected results go into a scoreboard queue when the op is driven
// and are popped when the DUT produces a load result, a bus write or an
// exception pulse.
module tb_mem_access_unit;
  import riscv_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result_M;
  logic [31:0] rs2_rdata_M;
  logic [2:0]  funct3_M;
  logic        MemRead_M;
  logic        MemWrite_M;
  logic        flush_M;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall_M;
  logic        load_valid_M;
  logic [31:0] load_data_M;
  logic        exc_M;
  logic [1:0]  exc_code_M;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result_M (alu_result_M),
    .rs2_rdata_M  (rs2_rdata_M),
    .funct3_M     (funct3_M),
    .MemRead_M    (MemRead_M),
    .MemWrite_M   (MemWrite_M),
    .flush_M      (flush_M),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .stall_M      (stall_M),
    .load_valid_M (load_valid_M),
    .load_data_M  (load_data_M),
    .exc_M        (exc_M),
    .exc_code_M   (exc_code_M)
  );

  typedef enum int {K_NONE = 0, K_LOAD = 1, K_STORE = 2, K_EXC = 3} kind_e;

  typedef struct {
    logic        memRead;
    logic        memWrite;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] rdata;
    int          waitCycles;
    kind_e       kind;
    logic [31:0] expData;
    logic [1:0]  expCode;
    logic [31:0] expAddr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    int          expStall;
    int          expReq;
  } vec_t;

  typedef struct {
    kind_e       kind;
    logic [31:0] data;
    logic [1:0]  code;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbQueue[$];
  vec_t vecs[$];

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Match one observed DUT output against the oldest scoreboard entry.
  task automatic popAndCheck(input string tag, input kind_e kind, input logic [31:0] data,
                             input logic [1:0] code, input logic [3:0] be, input logic [31:0] wdata);
    exp_t e;
    if (sbQueue.size() == 0) begin
      checkCount++;
      errorCount++;
      $display("[TB] FAIL %s.unexpected actual_kind=%0d expected=none", tag, int'(kind));
      return;
    end
    e = sbQueue.pop_front();
    checkOutput({tag, ".kind"}, 32'(int'(kind)), 32'(int'(e.kind)));
    if (kind == e.kind) begin
      case (kind)
        K_LOAD:  checkOutput({tag, ".ldata"}, data, e.data);
        K_EXC:   checkOutput({tag, ".code"}, 32'(code), 32'(e.code));
        K_STORE: begin
          checkOutput({tag, ".be"}, 32'(be), 32'(e.be));
          checkOutput({tag, ".wdata"}, wdata, e.wdata);
        end
        default: ;
      endcase
    end
  endtask

  task automatic clearInputs();
    MemRead_M    = 1'b0;
    MemWrite_M   = 1'b0;
    flush_M      = 1'b0;
    funct3_M     = 3'b000;
    alu_result_M = 32'h0;
    rs2_rdata_M  = 32'h0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".req"},    32'(dmem_req), 32'h0);
    checkOutput({tag, ".we"},     32'(dmem_we), 32'h0);
    checkOutput({tag, ".addr"},   dmem_addr, 32'h0);
    checkOutput({tag, ".wdata"},  dmem_wdata, 32'h0);
    checkOutput({tag, ".be"},     32'(dmem_be), 32'h0);
    checkOutput({tag, ".lvalid"}, 32'(load_valid_M), 32'h0);
    checkOutput({tag, ".ldata"},  load_data_M, 32'h0);
    checkOutput({tag, ".exc"},    32'(exc_M), 32'h0);
    checkOutput({tag, ".code"},   32'(exc_code_M), 32'h0);
    checkOutput({tag, ".stall"},  32'(stall_M), 32'h0);
  endtask

  // Drive one op into M, act as the memory, and hold the op until the
  // pipeline would have let it leave (stall_M low at a clock edge).
  task automatic applyStimulus(input vec_t v, input string tag);
    int   stallCycles = 0;
    int   reqCycles   = 0;
    int   waitCnt     = 0;
    int   lvCycles    = 0;
    int   excCycles   = 0;
    bit   leaving     = 1'b0;
    bit   firstReq    = 1'b1;
    exp_t e;
    if (v.kind != K_NONE) begin
      e.kind  = v.kind;
      e.data  = v.expData;
      e.code  = v.expCode;
      e.be    = v.expBe;
      e.wdata = v.expWdata;
      sbQueue.push_back(e);
    end
    for (int step = 0; step < v.expStall + 4; step++) begin
      @(negedge clk);
      if (load_valid_M) begin
        lvCycles++;
        popAndCheck(tag, K_LOAD, load_data_M, 2'b00, 4'h0, 32'h0);
      end
      if (exc_M) begin
        excCycles++;
        popAndCheck(tag, K_EXC, 32'h0, exc_code_M, 4'h0, 32'h0);
        leaving = 1'b1;
      end
      if (step == 0) begin
        MemRead_M    = v.memRead;
        MemWrite_M   = v.memWrite;
        flush_M      = v.flush;
        funct3_M     = v.funct3;
        alu_result_M = v.addr;
        rs2_rdata_M  = v.rs2;
      end else if (leaving) begin
        clearInputs();
      end
      dmem_ack = 1'b0;
      if (dmem_req) begin
        reqCycles++;
        if (firstReq) begin
          firstReq = 1'b0;
          checkOutput({tag, ".addr"}, dmem_addr, v.expAddr);
          checkOutput({tag, ".we"}, 32'(dmem_we), 32'(v.memWrite));
        end
        if (waitCnt == v.waitCycles) begin
          dmem_ack   = 1'b1;
          dmem_rdata = v.rdata;
          if (dmem_we) popAndCheck(tag, K_STORE, 32'h0, 2'b00, dmem_be, dmem_wdata);
        end else begin
          waitCnt++;
        end
      end
      #1;
      if (stall_M) stallCycles++;
      leaving = !stall_M;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    clearInputs();
    checkOutput({tag, ".stallCycles"}, 32'(stallCycles), 32'(v.expStall));
    checkOutput({tag, ".reqCycles"}, 32'(reqCycles), 32'(v.expReq));
    checkOutput({tag, ".lvCycles"}, 32'(lvCycles), (v.kind == K_LOAD) ? 32'h1 : 32'h0);
    checkOutput({tag, ".excCycles"}, 32'(excCycles), (v.kind == K_EXC) ? 32'h1 : 32'h0);
    checkOutput({tag, ".pending"}, 32'(sbQueue.size()), 32'h0);
    sbQueue.delete();
  endtask

  function automatic vec_t mkVec(input logic rd, input logic wr, input logic fl, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                                 input int waitCycles, input kind_e kind, input logic [31:0] expData,
                                 input logic [1:0] expCode, input logic [31:0] expAddr, input logic [3:0] expBe,
                                 input logic [31:0] expWdata, input int expStall, input int expReq);
    vec_t v;
    v.memRead = rd; v.memWrite = wr; v.flush = fl; v.funct3 = f3;
    v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.waitCycles = waitCycles;
    v.kind = kind; v.expData = expData; v.expCode = expCode; v.expAddr = expAddr;
    v.expBe = expBe; v.expWdata = expWdata; v.expStall = expStall; v.expReq = expReq;
    return v;
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    //                rd wr fl f3      addr          rs2           rdata        wait kind     expData       code   expAddr       be       expWdata      stall req
    vecs.push_back(mkVec(1, 0, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 2, K_LOAD,  32'hFFFF_FF80, 2'b00, 32'h0000_1000, 4'h0,    32'h0,        4,  3));
    vecs.push_back(mkVec(0, 1, 0, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,       0, K_STORE, 32'h0,        2'b00, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 2,  1));
    vecs.push_back(mkVec(1, 0, 0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,        0, K_EXC,   32'h0,        2'b01, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(1, 0, 0, 3'b010, 32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 1, K_LOAD,  32'hDEAD_BEEF, 2'b00, 32'h0000_4000, 4'h0,    32'h0,        3,  2));
    vecs.push_back(mkVec(1, 0, 0, 3'b100, 32'h0000_5001, 32'h0,        32'h1234_80FF, 0, K_LOAD,  32'h0000_0080, 2'b00, 32'h0000_5000, 4'h0,    32'h0,        2,  1));
    vecs.push_back(mkVec(1, 0, 0, 3'b001, 32'h0000_6002, 32'h0,        32'h8001_1234, 0, K_LOAD,  32'hFFFF_8001, 2'b00, 32'h0000_6000, 4'h0,    32'h0,        2,  1));
    vecs.push_back(mkVec(1, 0, 0, 3'b101, 32'h0000_6002, 32'h0,        32'h8001_1234, 0, K_LOAD,  32'h0000_8001, 2'b00, 32'h0000_6000, 4'h0,    32'h0,        2,  1));
    vecs.push_back(mkVec(1, 0, 0, 3'b001, 32'h0000_6000, 32'h0,        32'h8001_1234, 0, K_LOAD,  32'h0000_1234, 2'b00, 32'h0000_6000, 4'h0,    32'h0,        2,  1));
    vecs.push_back(mkVec(0, 1, 0, 3'b000, 32'h0000_7001, 32'hAABB_CC5A, 32'h0,       0, K_STORE, 32'h0,        2'b00, 32'h0000_7000, 4'b0010, 32'h5A5A_5A5A, 2,  1));
    vecs.push_back(mkVec(0, 1, 0, 3'b010, 32'h0000_8000, 32'h0123_4567, 32'h0,       3, K_STORE, 32'h0,        2'b00, 32'h0000_8000, 4'b1111, 32'h0123_4567, 5,  4));
    vecs.push_back(mkVec(1, 1, 0, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, K_EXC,   32'h0,        2'b11, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(1, 0, 0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, K_EXC,   32'h0,        2'b11, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(0, 1, 0, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, K_EXC,   32'h0,        2'b11, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(1, 0, 0, 3'b110, 32'h0000_0100, 32'h0,        32'h0,        0, K_EXC,   32'h0,        2'b11, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(1, 0, 0, 3'b001, 32'h0000_6001, 32'h0,        32'h0,        0, K_EXC,   32'h0,        2'b01, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(0, 1, 0, 3'b010, 32'h0000_8002, 32'h0,        32'h0,        0, K_EXC,   32'h0,        2'b01, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(1, 0, 1, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        0, K_NONE,  32'h0,        2'b00, 32'h0,         4'h0,    32'h0,        0,  0));
    vecs.push_back(mkVec(1, 0, 0, 3'b010, 32'h0000_9000, 32'h0,        32'h0,     1000, K_EXC,   32'h0,        2'b10, 32'h0000_9000, 4'h0,    32'h0,       17, 16));
    vecs.push_back(mkVec(1, 0, 0, 3'b000, 32'h0000_1002, 32'h0,        32'h0055_0000, 0, K_LOAD,  32'h0000_0055, 2'b00, 32'h0000_1000, 4'h0,    32'h0,        2,  1));

    rst        = 1'b1;
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    clearInputs();
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while a load is waiting on the bus, then a stray late ack.
    @(negedge clk);
    MemRead_M    = 1'b1;
    funct3_M     = 3'b010;
    alu_result_M = 32'h0000_A000;
    @(negedge clk);
    checkOutput("rstBusy.reqUp", 32'(dmem_req), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    clearInputs();
    @(negedge clk);
    checkAllZero("rstBusy");
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("lateAck.req", 32'(dmem_req), 32'h0);
    @(negedge clk);
    checkOutput("lateAck.lvalid", 32'(load_valid_M), 32'h0);
    checkOutput("lateAck.ldata", load_data_M, 32'h0);
    checkOutput("lateAck.exc", 32'(exc_M), 32'h0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit sitting directly downstream of the EX/M pipeline register. It consumes the registered effective address, store data, funct3 and memory-control bits of the M stage. It then runs one data-memory transaction over a req/ack bus and returns aligned, sign- or zero-extended load data toward the M/WB register. It stalls the upstream pipeline while a transaction is outstanding and flags misaligned, illegal or timed-out accesses.

## Interface
Parameters:
- TIMEOUT, default 16: max cycles waiting for dmem_ack before a bus error (≥1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_result_M  in  32  effective byte address.
- rs2_rdata_M  in  32  store source data.
- funct3_M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- MemRead_M  in  1  load in M stage.
- MemWrite_M  in  1  store in M stage.
- flush_M  in  1  current M instruction is squashed.
- dmem_req  out  1  bus request, held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address ({addr[31:2],2'b00}).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  one-cycle completion; dmem_rdata valid same cycle.
- dmem_rdata  in  32  read word.
- stall_M  out  1  freeze PC/IF/ID/EX/M registers.
- load_valid_M  out  1  one-cycle pulse, load_data_M valid.
- load_data_M  out  32  extended load result.
- exc_M  out  1  one-cycle exception pulse.
- exc_code_M  out  2  01 misaligned, 10 bus timeout, 11 illegal access.

## Operation
- FSM states IDLE, BUSY, RESP. Reset: IDLE, all registered outputs 0 (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, load_valid_M, load_data_M, exc_M, exc_code_M, timeout counter).
- IDLE, access = (MemRead_M | MemWrite_M) & !flush_M:
  - Illegal: both MemRead_M and MemWrite_M, or funct3 ∈ {011,110,111}, or store with funct3[2]=1. Next cycle exc_M=1, code 11. Stay IDLE, no request.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0. Next cycle exc_M=1, code 01. No request.
  - Otherwise register dmem_addr, dmem_we, dmem_be, dmem_wdata, the load size and addr[1:0]; set dmem_req=1; go BUSY; clear the counter.
- Store lanes: SB is be=0001<<addr[1:0] with wdata={4{rs2[7:0]}}. SH is be=addr[1]?1100:0011 with wdata={2{rs2[15:0]}}. SW is be=1111 with wdata=rs2.
- BUSY: on dmem_ack, drop dmem_req and go RESP. For loads, select the byte/half at the saved offset, extend it per funct3, and register into load_data_M. Without ack, increment the counter. When the counter reaches TIMEOUT-1 without ack, drop dmem_req, pulse exc_M code 10 and return to IDLE.
- RESP: load_valid_M=1 for loads only (0 for stores). Return to IDLE.
- flush_M is sampled only in IDLE. A started transaction always completes on the bus.

## Timing
- stall_M is combinational: 1 in IDLE when a legal aligned access is present, and 1 in BUSY. It is 0 in RESP, so the instruction leaves M at the end of RESP.
- Latency: detect at cycle 0, dmem_req high from cycle 1, ack at cycle k≥1, RESP at k+1. Minimum 3 cycles in M for zero-wait memory.
- Exception cases never raise stall_M. The pulse appears the cycle after detection. Downstream flush logic discards the instruction.
- dmem_addr, dmem_we, dmem_be and dmem_wdata are stable while dmem_req=1.
- dmem_ack outside BUSY is ignored.
- rst in any state: next cycle IDLE with dmem_req=0. A pending bus transaction is abandoned.

## Structure
- riscv_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), exc code constants, FSM state typedef.
- Sub-module lsu_align is combinational. Its store path takes addr[1:0], size and data and produces be and wdata. Its load path takes rdata, offset and funct3 and produces the extended result. It is instantiated once for each direction.

## Test plan
- LB at addr 0x1003, rdata 0x80FF_0000, ack after 2 wait cycles → dmem_addr 0x1000; load_data_M 0xFFFF_FF80; load_valid_M one cycle; stall_M high exactly 4 cycles.
- SH at 0x2002, rs2 0x1234_ABCD, zero-wait → dmem_be 1100, dmem_wdata 0xABCD_ABCD, dmem_we 1, no load_valid_M.
- LW at 0x3001 → exc_M code 01 next cycle; dmem_req never rises; stall_M stays 0.
- LW, no ack, TIMEOUT=16 → dmem_req drops after 16 cycles high; exc_M code 10; back to IDLE.
- MemRead and MemWrite both 1, or funct3=011 → exc_M code 11. Also flush_M=1 with a load → no request, no exception.
- rst asserted in BUSY → next cycle dmem_req=0 and all outputs 0. A late dmem_ack is ignored.
